// File: rtl/memory_mfc_responder.sv
// memory_mfc_responder
// ---------------------------------------------------------------------------
// Responder end of the EN / R_W / MFC memory handshake. It accepts a read or
// write from the control FSMs, using the address from MAR and write data from
// MDR. After LATENCY rising edges it accesses an internal synchronous RAM and
// raises MFC. MFC is held until the requester drops EN.
//
// Handshake (4-phase):
//   The requester raises EN and holds it with R_W/address/data_in valid.
//   The request is accepted on the first edge where EN=1 and the responder
//   is idle. From then on, the request inputs are ignored.
//   MFC rises LATENCY edges after acceptance and stays high while EN=1.
//   The requester must then drop EN for at least one edge before it issues
//   another request.
//   If EN drops before MFC, the transaction is aborted: no RAM write takes
//   place and data_out keeps its previous value.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   EN         request enable, held for the whole transaction
//   R_W        1 = read, 0 = write (latched at acceptance)
//   address    word address from MAR (latched at acceptance)
//   data_in    write data from MDR (latched at acceptance)
//   data_out   last completed read data, registered
//   MFC        memory function complete, registered
//   busy       high in WAIT and DONE, registered
//   state_dbg  current FSM state (0 = IDLE, 1 = WAIT, 2 = DONE)
// ---------------------------------------------------------------------------
module memory_mfc_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2     // legal range 1..15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  EN,
    input  logic                  R_W,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  MFC,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = 4;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        count;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic                    mem_we;

    assign state_dbg = state;

    // The write happens on the same edge that raises MFC. Reset and abort
    // both suppress it.
    assign mem_we = (state == S_WAIT) && EN && (count == '0) && !rw_q && !reset;

    // The RAM has no reset, so its contents survive a reset.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            data_out <= '0;
            MFC      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    MFC <= 1'b0;
                    if (EN) begin
                        rw_q   <= R_W;
                        addr_q <= address;
                        data_q <= data_in;
                        count  <= CNT_W'(LATENCY - 1);
                        busy   <= 1'b1;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!EN) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        if (rw_q) begin
                            data_out <= mem[addr_q];
                        end
                        MFC   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Hold MFC until the requester releases EN. No new
                    // request can start until the FSM has passed through IDLE.
                    if (!EN) begin
                        MFC   <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    MFC   <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
